scfifo_pack: RTL

- Narrow-to-wide packing synchronous FIFO. It is the write-side counterpart of the team's wide-to-narrow unpacking FIFO.
- Accepts I_WIDTH words and assembles them MSB-first into O_WIDTH words. Stores complete wide words in a DEPTH-entry memory and serves them to a wide reader.
- Used where byte/halfword streams must be regrouped into bus-width words before a wide consumer.

---
 rtl/scfifo_pack_if.sv | 34 +++
 rtl/scfifo_pack.sv | 121 ++++++++++++
 2 files changed

// File: rtl/scfifo_pack_if.sv
// Bus bundle for the narrow-to-wide packing FIFO: narrow write side, wide read side, status.
interface scfifo_pack_if #(
    parameter int DEPTH   = 32,
    parameter int I_WIDTH = 8,
    parameter int O_WIDTH = 32
);
    localparam int R  = O_WIDTH / I_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LW = $clog2(R) + 1;

    logic               wr_en;
    logic [I_WIDTH-1:0] din;
    logic               wr_flush;
    logic               fifo_clr;
    logic               rd_en;
    logic [O_WIDTH-1:0] dout;
    logic               dout_valid;
    logic               empty;
    logic               full;
    logic [CW-1:0]      level;
    logic [LW-1:0]      lane;
    logic               overflow;
    logic               underflow;

    modport master (
        output wr_en, din, wr_flush, fifo_clr, rd_en,
        input  dout, dout_valid, empty, full, level, lane, overflow, underflow
    );

    modport slave (
        input  wr_en, din, wr_flush, fifo_clr, rd_en,
        output dout, dout_valid, empty, full, level, lane, overflow, underflow
    );
endinterface

// File: rtl/scfifo_pack.sv
// Packing FIFO: narrow words are assembled MSB-first into wide words, which are
// stored in a DEPTH-entry memory and read back one wide word per cycle.
module scfifo_pack #(
    parameter int DEPTH   = 32,
    parameter int I_WIDTH = 8,
    parameter int O_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    scfifo_pack_if.slave  bus
);
    localparam int R  = O_WIDTH / I_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(R) + 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(R - 1);

    logic [O_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic [CW-1:0]      count_next;
    logic [LW-1:0]      lane_reg;
    logic [O_WIDTH-1:0] asm_reg;
    logic [O_WIDTH-1:0] asm_next;
    logic [O_WIDTH-1:0] dout_reg;
    logic               dout_valid_reg;
    logic               overflow_reg;
    logic               underflow_reg;

    logic empty;
    logic full;
    logic wr_acc;
    logic rd_acc;
    logic commit;

    assign empty  = (count_reg == '0);
    assign full   = (count_reg == CW'(DEPTH));
    assign wr_acc = bus.wr_en & ~full;
    assign rd_acc = bus.rd_en & ~empty;

    // Flush still needs either held lanes or a same-cycle write to have anything to commit
    assign commit = (wr_acc & (lane_reg == LAST_LANE))
                  | (bus.wr_flush & ~full & ((lane_reg != '0) | wr_acc));

    // Assembly word as it stands after placing an accepted din in its lane
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_lane
            assign asm_next[O_WIDTH-1-I_WIDTH*gi -: I_WIDTH] =
                (wr_acc && lane_reg == LW'(gi)) ? bus.din
                                                : asm_reg[O_WIDTH-1-I_WIDTH*gi -: I_WIDTH];
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (commit && !rd_acc)
            count_next = count_reg + CW'(1);
        else if (!commit && rd_acc)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (commit && !bus.fifo_clr)
            mem[wr_ptr_reg] <= asm_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            lane_reg       <= '0;
            asm_reg        <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            overflow_reg  <= bus.wr_en & full;
            underflow_reg <= bus.rd_en & empty;
            if (bus.fifo_clr) begin
                wr_ptr_reg     <= '0;
                rd_ptr_reg     <= '0;
                count_reg      <= '0;
                lane_reg       <= '0;
                asm_reg        <= '0;
                dout_reg       <= '0;
                dout_valid_reg <= 1'b0;
            end else begin
                count_reg <= count_next;
                if (rd_acc) begin
                    dout_reg       <= mem[rd_ptr_reg];
                    dout_valid_reg <= 1'b1;
                    rd_ptr_reg     <= rd_ptr_reg + AW'(1);
                end else begin
                    dout_reg       <= '0;
                    dout_valid_reg <= 1'b0;
                end
                if (commit) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    lane_reg   <= '0;
                    asm_reg    <= '0;
                end else if (wr_acc) begin
                    lane_reg <= lane_reg + LW'(1);
                    asm_reg  <= asm_next;
                end
            end
        end
    end

    assign bus.dout       = dout_reg;
    assign bus.dout_valid = dout_valid_reg;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.level      = count_reg;
    assign bus.lane       = lane_reg;
    assign bus.overflow   = overflow_reg;
    assign bus.underflow  = underflow_reg;
endmodule
